// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_lsu
// Function : MEM-stage load/store unit for a word-organised data memory.
//            Byte/halfword/word loads with sign/zero extension (1-cycle
//            registered response); word stores in a single cycle; sub-word
//            stores as a 2-cycle read-modify-write that stalls once.
// Option   : define LSU_BOUNDS_CHECK_EN to fault word indices >= MEM_WORDS.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lsu #(
   parameter int MEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        misaligned,
   output logic        mem_we,
   output logic        mem_re,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

`ifdef LSU_BOUNDS_CHECK_EN
   localparam logic C_BOUNDS_EN = 1'b1;
`else
   localparam logic C_BOUNDS_EN = 1'b0;
`endif

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        misaligned_q, misaligned_d;
   logic [31:0] merge_q, merge_d;

   // Request decode: access size, legality, alignment and (optional) range.
   logic w_is_byte, w_is_half, w_is_word;
   logic w_legal, w_aligned, w_oob, w_fault;

   assign w_is_byte = (req_funct3[1:0] == 2'b00);
   assign w_is_half = (req_funct3[1:0] == 2'b01);
   assign w_is_word = (req_funct3[1:0] == 2'b10);

   // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
   assign w_legal = req_we ? (!req_funct3[2] && (req_funct3[1:0] != 2'b11))
                           : ((req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]));

   assign w_aligned = w_is_byte
                    | (w_is_half && !req_addr[0])
                    | (w_is_word && (req_addr[1:0] == 2'b00));

   assign w_oob   = C_BOUNDS_EN && ({2'b00, req_addr[31:2]} >= $unsigned(MEM_WORDS));
   assign w_fault = !w_legal || !w_aligned || w_oob;

   // Load lane extraction and extension (little-endian lanes).
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [31:0] w_ld_ext;

   assign w_ld_byte = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
   assign w_ld_half = mem_rdata[{req_addr[1], 4'b0000} +: 16];

   // Select sign- or zero-extended lane according to the load width code.
   always_comb begin
      w_ld_ext = mem_rdata;
      case (req_funct3)
         3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
         3'b100:  w_ld_ext = {24'h0, w_ld_byte};
         3'b101:  w_ld_ext = {16'h0, w_ld_half};
         default: w_ld_ext = mem_rdata;
      endcase
   end

   // Merge the store lane into the word captured during the read phase.
   logic [31:0] w_merged;

   always_comb begin
      w_merged = merge_q;
      if (w_is_byte) begin
         w_merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      end else begin
         w_merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
      end
   end

   // Next-state, registered-result and memory-control logic.
   logic        w_stall, w_mem_we, w_mem_re;
   logic [31:0] w_mem_wdata;

   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      misaligned_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      merge_d      = merge_q;
      w_stall      = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_re     = 1'b0;
      w_mem_wdata  = req_wdata;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (w_fault) begin
                  misaligned_d = 1'b1;
               end else if (!req_we) begin
                  w_mem_re     = 1'b1;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = w_ld_ext;
               end else if (w_is_word) begin
                  w_mem_we = 1'b1;
               end else begin
                  // Sub-word store: fetch the containing word first.
                  w_mem_re = 1'b1;
                  w_stall  = 1'b1;
                  merge_d  = mem_rdata;
                  state_d  = RMW_WR;
               end
            end
         end
         RMW_WR: begin
            w_mem_we    = 1'b1;
            w_mem_wdata = w_merged;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset aborts any pending write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         misaligned_q <= 1'b0;
         merge_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         misaligned_q <= misaligned_d;
         merge_q      <= merge_d;
      end
   end

   // Combinational outputs are forced low while reset is asserted.
   assign stall      = rst_n & w_stall;
   assign mem_we     = rst_n & w_mem_we;
   assign mem_re     = rst_n & w_mem_re;
   assign mem_addr   = rst_n ? {2'b00, req_addr[31:2]} : 32'h0;
   assign mem_wdata  = rst_n ? w_mem_wdata : 32'h0;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign misaligned = misaligned_q;

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit between the EX/MEM pipeline register and the word-organised data memory in the MEM stage.
- Converts byte addresses to word indices and performs byte, halfword and word accesses.
- Sign/zero-extends load data and registers it toward MEM/WB.
- Implements sub-word stores as a 2-cycle read-modify-write, stalling the pipeline for one cycle.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory; word index width is clog2(MEM_WORDS).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  MEM-stage instruction is a load or store this cycle
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I width/sign code
- req_addr  input  32  byte address from ALU
- req_wdata  input  32  store data (rs2)
- stall  output  1  hold upstream pipeline registers; request must stay stable while high
- resp_valid  output  1  registered load-complete pulse
- resp_rdata  output  32  registered extended load data
- misaligned  output  1  registered pulse for misaligned or illegal access
- mem_we  output  1  data memory write enable
- mem_re  output  1  data memory read enable
- mem_addr  output  32  word index = req_addr[31:2]
- mem_wdata  output  32  data memory write data
- mem_rdata  input  32  data memory combinational read data

Behaviour:
- Reset:
  - State IDLE.
  - resp_valid, resp_rdata, misaligned, stall, mem_we, mem_re all 0; mem_addr and mem_wdata 0.
- Memory model: combinational read gated by mem_re; synchronous write on the rising edge when mem_we=1.
- funct3 codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal: no memory access, misaligned pulses.
- Alignment:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - A violation issues no memory access, sets misaligned=1 for one cycle, and forces resp_valid=0.
- Byte lane = addr[1:0]; halfword lane = addr[1]. Little-endian: byte 0 is bits [7:0].
- States: IDLE, RMW_WR.
- IDLE with a load:
  - mem_re=1 combinationally.
  - Extracted lane is sign- or zero-extended.
  - Next edge: resp_rdata <= extended value, resp_valid <= 1.
  - Latency 1, no stall.
- IDLE with SW: mem_we=1, mem_wdata=req_wdata in the same cycle; no stall; write commits on that edge.
- IDLE with SB/SH:
  - mem_re=1, stall=1.
  - Next edge: latch mem_rdata into merge register; go to RMW_WR.
- RMW_WR:
  - mem_we=1, mem_wdata = merge register with the target lane replaced by req_wdata[7:0] or [15:0].
  - stall=0, mem_re=0.
  - Next edge: return to IDLE.
- Stores never assert resp_valid.
- resp_valid and misaligned are single-cycle pulses, cleared on the next edge unless re-triggered.
- req_valid=0 in IDLE: mem_we=mem_re=0; mem_addr still tracks req_addr.
- Back-to-back requests:
  - A new request is accepted every cycle while stall=0.
  - A load directly after RMW_WR observes the freshly written word.
- Reset asserted in RMW_WR: abort immediately; no write occurs.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined:
  - A word index >= MEM_WORDS is flagged by misaligned (access fault) on the next edge.
  - No memory access is made; mem_we and mem_re are held 0.
- Undefined:
  - No check is made.
  - mem_addr passes through untruncated; the memory wraps on its low index bits.

Test Plan:
- Load word: bench preloads word 3 = 0x8001_7FFF; LW addr 0x0C -> mem_re=1, mem_addr=3; next cycle resp_valid=1, resp_rdata=0x8001_7FFF.
- Sub-word loads (word 3 as above):
  - LB addr 0x0F -> 0xFFFF_FF80; LBU 0x0F -> 0x0000_0080.
  - LH 0x0C -> 0x0000_7FFF; LHU 0x0E -> 0x0000_8001.
- Byte store RMW: word 2 = 0x1122_3344; SB addr 0x09, wdata 0xAB:
  - stall=1 for exactly 1 cycle.
  - RMW_WR cycle has mem_we=1, mem_wdata=0x1122_AB44.
  - Following LW 0x08 returns 0x1122_AB44.
- Word store: SW addr 0x10, wdata 0xDEAD_BEEF -> same-cycle mem_we=1, stall=0; LW 0x10 next cycle returns 0xDEAD_BEEF.
- Misaligned:
  - LW 0x02 -> misaligned=1 one cycle, resp_valid=0, mem_re=0.
  - SH 0x05 -> misaligned=1, no write, target word unchanged.
- Reset mid-RMW: SH addr 0x04, wdata 0x5555; drop rst_n during RMW_WR -> mem_we falls to 0 immediately; word 1 unchanged; all outputs 0.
- With LSU_BOUNDS_CHECK_EN, MEM_WORDS=256: LW addr 0x400 -> misaligned=1, mem_re=0.
